// File: rtl/csel_sub_seq_pkg.sv
// Shared types and sizing helpers for the carry-select (borrow-select) sequential subtractor.
package csel_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_DEF = 4;

    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-slice build still needs a 1-bit index register
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_w(nslice(16, SLICE_DEF));

endpackage

// File: rtl/csel_sub_seq_if.sv
// Operand/result handshake bundle. The ovf signal exists only when CSEL_SUB_OVF_EN is defined.
interface csel_sub_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef CSEL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
`ifdef CSEL_SUB_OVF_EN
        input  ovf,
`endif
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
`ifdef CSEL_SUB_OVF_EN
        output ovf,
`endif
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/csel_sub_seq_borrow_sel_slice.sv
// One SLICE-bit subtract slice: both borrow-in outcomes are precomputed, the borrow picks one.
module borrow_sel_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] as,
    input  logic [SLICE-1:0] bs,
    input  logic             sel,
    output logic [SLICE-1:0] ds,
    output logic             bo
);
    logic [SLICE:0] d0_s;
    logic [SLICE:0] d1_s;

    // The extra MSB of each candidate is its borrow-out
    assign d0_s = {1'b0, as} - {1'b0, bs};
    assign d1_s = d0_s - (SLICE+1)'(1);

    assign ds = sel ? d1_s[SLICE-1:0] : d0_s[SLICE-1:0];
    assign bo = sel ? d1_s[SLICE]     : d0_s[SLICE];

endmodule

// File: rtl/csel_sub_seq.sv
// Multi-cycle borrow-select subtractor, diff = a - b - bin, one slice per clock.
// Optional signed-overflow output enabled by defining CSEL_SUB_OVF_EN.
module csel_sub_seq
    import csel_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = SLICE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    csel_sub_seq_if.slave bus
);
    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int IDXW   = idx_w(NSLICE);

    state_e           state_r;
    state_e           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             bout_r;
    logic [IDXW-1:0]  idx_r;
    logic [SLICE-1:0] as_s;
    logic [SLICE-1:0] bs_s;
    logic [SLICE-1:0] ds_s;
    logic             bo_s;
    logic             last_s;
`ifdef CSEL_SUB_OVF_EN
    logic             ovf_r;
`endif

    assign as_s   = a_r[idx_r*SLICE +: SLICE];
    assign bs_s   = b_r[idx_r*SLICE +: SLICE];
    assign last_s = (idx_r == IDXW'(NSLICE-1));

    borrow_sel_slice #(.SLICE(SLICE)) u_slice (
        .as  (as_s),
        .bs  (bs_s),
        .sel (borrow_r),
        .ds  (ds_s),
        .bo  (bo_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_s = RUN;
                else              state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Operand capture and per-slice result/borrow update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            bout_r   <= 1'b0;
            idx_r    <= '0;
`ifdef CSEL_SUB_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r      <= bus.a;
                        b_r      <= bus.b;
                        borrow_r <= bus.bin;
                        idx_r    <= '0;
                        diff_r   <= '0;
                    end
                end
                RUN: begin
                    diff_r[idx_r*SLICE +: SLICE] <= ds_s;
                    borrow_r <= bo_s;
                    idx_r    <= last_s ? '0 : idx_r + IDXW'(1);
                    if (last_s) begin
                        bout_r <= bo_s;
`ifdef CSEL_SUB_OVF_EN
                        // Final slice's top bit is the result MSB
                        ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                  (ds_s[SLICE-1] != a_r[WIDTH-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
`ifdef CSEL_SUB_OVF_EN
    assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_csel_sub_seq.sv
// Self-checking bench for csel_sub_seq: directed corner cases, back-pressure, mid-run reset, random ops.
// Checks ovf as well when CSEL_SUB_OVF_EN is defined.
module tb_csel_sub_seq;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    csel_sub_seq_if #(.WIDTH(16)) bus ();

    csel_sub_seq #(.WIDTH(16), .SLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic from the definition of subtraction with borrow
    function automatic logic [15:0] ref_diff(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int t;
        t = int'(a) - int'(b) - int'(bin);
        if (t < 0) t = t + 65536;
        return 16'(t);
    endfunction

    function automatic logic ref_bout(input logic [15:0] a, input logic [15:0] b, input logic bin);
        return (int'(a) < int'(b) + int'(bin));
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input int hold, input string tag);
        int          lat;
        logic [15:0] ed;
        logic        eb;
        ed = ref_diff(a, b, bin);
        eb = ref_bout(a, b, bin);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.bin      = 1'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
`ifdef CSEL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'((a[15] != b[15]) && (ed[15] != a[15])));
`endif
        // Back-pressure: new operands offered while the result is waiting
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, "_hold_diff"}, 32'(bus.diff), 32'(ed));
            chk({tag, "_hold_bout"}, 32'(bus.bout), 32'(eb));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_release_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 16'h0000;
        bus.b         = 16'h0000;
        bus.bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_diff", 32'(bus.diff), 32'd0);
        chk("reset_bout", 32'(bus.bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h0234, 1'b0, 0, "basic");
        chk("basic_value", 32'(ref_diff(16'h1234, 16'h0234, 1'b0)), 32'h1000);
        run_op(16'h0000, 16'h0001, 1'b0, 0, "ripple");
        run_op(16'h5555, 16'h5555, 1'b1, 0, "eq_bin1");
        run_op(16'h5555, 16'h5555, 1'b0, 0, "eq_bin0");
        run_op(16'h0000, 16'h0000, 1'b1, 0, "zero_bin");
        run_op(16'h8000, 16'h0001, 1'b0, 0, "ovf_neg");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, "ovf_pos");
        run_op(16'hBEEF, 16'h1234, 1'b1, 5, "backpressure");

        // Reset in the middle of RUN
        @(negedge clk);
        bus.a        = 16'h0F0F;
        bus.b        = 16'h0101;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrun_rst_diff", 32'(bus.diff), 32'd0);
        chk("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrun_rst_bout", 32'(bus.bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("midrun_no_stale_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op(16'h0F0F, 16'h0101, 1'b0, 1, "after_rst");

        for (int i = 0; i < 25; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
